wb_byte_stream_slave: RTL and testbench

WB_BYTE_STREAM_SLAVE -- requirements
Module: wb_byte_stream_slave

---
 rtl/wb_byte_stream_slave_pkg.sv | 36 +++
 rtl/wb_byte_stream_slave_if.sv | 23 ++
 rtl/wb_byte_stream_slave_fifo.sv | 65 ++++++
 rtl/wb_byte_stream_slave.sv | 143 ++++++++++++++
 tb/tb_wb_byte_stream_slave.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_byte_stream_slave_pkg.sv
// Shared register map, bit indices and types for the Wishbone byte-stream slave.
package wb_byte_stream_pkg;

   localparam int DEFAULT_DEPTH = 16;

   localparam logic [2:0] ADR_DATA   = 3'd0;
   localparam logic [2:0] ADR_STATUS = 3'd1;
   localparam logic [2:0] ADR_CTRL   = 3'd2;
   localparam logic [2:0] ADR_TXCNT  = 3'd3;
   localparam logic [2:0] ADR_RXCNT  = 3'd4;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_FULL  = 2;
   localparam int ST_RX_EMPTY = 3;
   localparam int ST_RX_OVR   = 4;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_RX_IE = 1;
   localparam int CTRL_TX_IE = 2;
   localparam int CTRL_FLUSH = 7;

   typedef struct packed {
      logic tx_ie;
      logic rx_ie;
      logic en;
   } ctrl_t;

   typedef enum logic [1:0] {
      TERM_NONE,
      TERM_ACK,
      TERM_ERR,
      TERM_RTY
   } term_e;

endpackage

// File: rtl/wb_byte_stream_slave_if.sv
// Wishbone slave-side bus bundle; signal names follow the slave's point of view.
interface wb_byte_stream_slave_if;
   logic [2:0] wb_adr_i;
   logic [7:0] wb_dat_i;
   logic [7:0] wb_dat_o;
   logic       wb_we_i;
   logic       wb_stb_i;
   logic       wb_cyc_i;
   logic       wb_ack_o;
   logic       wb_err_o;
   logic       wb_rty_o;
   logic       wb_inta_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, wb_inta_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, wb_inta_o
   );
endinterface

// File: rtl/wb_byte_stream_slave_fifo.sv
// Byte FIFO with occupancy count; full/empty come from the current count and
// flush overrides any push or pop in the same cycle.
module byte_fifo #(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [7:0]    din_i,
   output logic [7:0]    dout_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // NOTE: every next-state variable is given a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage has no reset; pointers and count define which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end
endmodule

// File: rtl/wb_byte_stream_slave.sv
// Wishbone register slave bridging a TX and an RX byte stream through two FIFOs,
// with one wait state per access and a registered interrupt.
module wb_byte_stream_slave
   import wb_byte_stream_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   wb_byte_stream_slave_if.slave wb,
   output logic [7:0]            tx_data_o,
   output logic                  tx_valid_o,
   input  logic                  tx_ready_i,
   input  logic [7:0]            rx_data_i,
   input  logic                  rx_valid_i,
   output logic                  rx_ready_o
);
   ctrl_t         ctrl_q, ctrl_d;
   term_e         term_q, term_d;
   logic          rx_ovr_q, rx_ovr_d;
   logic          inta_q, inta_d;
   logic [7:0]    dat_q, dat_d;
   logic [7:0]    status, ctrl_rd, rx_dout;
   logic          req, wb_push, wb_pop, ctrl_wr, flush;
   logic          tx_pop, rx_push;
   logic [CW-1:0] tx_count, rx_count;
   logic          tx_full, tx_empty, rx_full, rx_empty;

   assign req = wb.wb_cyc_i & wb.wb_stb_i & ~(wb.wb_ack_o | wb.wb_err_o | wb.wb_rty_o);

   assign tx_valid_o = ctrl_q.en & ~tx_empty;
   assign rx_ready_o = ctrl_q.en & ~rx_full;
   assign tx_pop     = tx_valid_o & tx_ready_i;
   assign rx_push    = rx_valid_i & rx_ready_o;
   assign flush      = ctrl_wr & wb.wb_dat_i[CTRL_FLUSH];

   always_comb begin
      status                = '0;
      status[ST_TX_FULL]    = tx_full;
      status[ST_TX_EMPTY]   = tx_empty;
      status[ST_RX_FULL]    = rx_full;
      status[ST_RX_EMPTY]   = rx_empty;
      status[ST_RX_OVR]     = rx_ovr_q;
      ctrl_rd               = '0;
      ctrl_rd[CTRL_EN]      = ctrl_q.en;
      ctrl_rd[CTRL_RX_IE]   = ctrl_q.rx_ie;
      ctrl_rd[CTRL_TX_IE]   = ctrl_q.tx_ie;
   end

   // Access decode: all side effects and read data are taken in the req cycle.
   always_comb begin
      term_d  = TERM_NONE;
      dat_d   = dat_q;
      wb_push = 1'b0;
      wb_pop  = 1'b0;
      ctrl_wr = 1'b0;
      if (req) begin
         term_d = TERM_ACK;
         dat_d  = '0;
         case (wb.wb_adr_i)
            ADR_DATA: begin
               if (wb.wb_we_i) begin
                  if (tx_full) term_d = TERM_RTY;
                  else         wb_push = 1'b1;
               end else if (rx_empty) begin
                  term_d = TERM_RTY;
               end else begin
                  wb_pop = 1'b1;
                  dat_d  = rx_dout;
               end
            end
            ADR_STATUS: if (!wb.wb_we_i) dat_d = status;
            ADR_CTRL: begin
               if (wb.wb_we_i) ctrl_wr = 1'b1;
               else            dat_d   = ctrl_rd;
            end
            ADR_TXCNT: if (!wb.wb_we_i) dat_d = 8'(tx_count);
            ADR_RXCNT: if (!wb.wb_we_i) dat_d = 8'(rx_count);
            default:   term_d = TERM_ERR;
         endcase
      end
   end

   always_comb begin
      ctrl_d = ctrl_q;
      if (ctrl_wr) begin
         ctrl_d.en    = wb.wb_dat_i[CTRL_EN];
         ctrl_d.rx_ie = wb.wb_dat_i[CTRL_RX_IE];
         ctrl_d.tx_ie = wb.wb_dat_i[CTRL_TX_IE];
      end
      rx_ovr_d = flush ? 1'b0 : (rx_ovr_q | (rx_valid_i & ctrl_q.en & rx_full));
      inta_d   = (ctrl_q.rx_ie & (~rx_empty | rx_ovr_q)) | (ctrl_q.tx_ie & tx_empty);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ctrl_q   <= '0;
         term_q   <= TERM_NONE;
         rx_ovr_q <= 1'b0;
         inta_q   <= 1'b0;
         dat_q    <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         term_q   <= term_d;
         rx_ovr_q <= rx_ovr_d;
         inta_q   <= inta_d;
         dat_q    <= dat_d;
      end
   end

   assign wb.wb_ack_o  = (term_q == TERM_ACK);
   assign wb.wb_err_o  = (term_q == TERM_ERR);
   assign wb.wb_rty_o  = (term_q == TERM_RTY);
   assign wb.wb_dat_o  = dat_q;
   assign wb.wb_inta_o = inta_q;

   byte_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (wb_push),
      .pop_i   (tx_pop),
      .flush_i (flush),
      .din_i   (wb.wb_dat_i),
      .dout_o  (tx_data_o),
      .count_o (tx_count),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   byte_fifo #(.DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (rx_push),
      .pop_i   (wb_pop),
      .flush_i (flush),
      .din_i   (rx_data_i),
      .dout_o  (rx_dout),
      .count_o (rx_count),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );
endmodule

// File: tb/tb_wb_byte_stream_slave.sv
// Randomized bench for wb_byte_stream_slave against a queue-based register/stream model.
module tb_wb_byte_stream_slave;
   import wb_byte_stream_pkg::*;

   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [7:0] rx_data  = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;

   wb_byte_stream_slave_if wb ();

   wb_byte_stream_slave #(.DEPTH(DEPTH), .CW(CW)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wb         (wb),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .tx_ready_i (tx_ready),
      .rx_data_i  (rx_data),
      .rx_valid_i (rx_valid),
      .rx_ready_o (rx_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model
   logic [7:0] m_tx[$];
   logic [7:0] m_rx[$];
   bit m_en, m_rxie, m_txie, m_ovr;

   localparam logic [2:0] T_ACK = 3'b100, T_ERR = 3'b010, T_RTY = 3'b001;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] m_status();
      return {3'b000, m_ovr, m_rx.size() == 0, m_rx.size() == DEPTH,
              m_tx.size() == 0, m_tx.size() == DEPTH};
   endfunction

   function automatic logic m_inta();
      return (m_rxie && (m_rx.size() > 0 || m_ovr)) || (m_txie && m_tx.size() == 0);
   endfunction

   task automatic m_reset();
      m_tx.delete(); m_rx.delete();
      m_en = 0; m_rxie = 0; m_txie = 0; m_ovr = 0;
   endtask

   task automatic model_wb(input bit we, input logic [2:0] adr, input logic [7:0] d,
                           output logic [2:0] term, output logic [7:0] rd);
      term = T_ACK;
      rd   = 8'h00;
      case (adr)
         3'd0: begin
            if (we) begin
               if (m_tx.size() == DEPTH) term = T_RTY;
               else m_tx.push_back(d);
            end else if (m_rx.size() == 0) term = T_RTY;
            else rd = m_rx.pop_front();
         end
         3'd1: if (!we) rd = m_status();
         3'd2: begin
            if (we) begin
               m_en = d[0]; m_rxie = d[1]; m_txie = d[2];
               if (d[7]) begin m_tx.delete(); m_rx.delete(); m_ovr = 0; end
            end else rd = {5'b0, m_txie, m_rxie, m_en};
         end
         3'd3: if (!we) rd = 8'(m_tx.size());
         3'd4: if (!we) rd = 8'(m_rx.size());
         default: term = T_ERR;
      endcase
   endtask

   // Called and returns at posedge+1.
   task automatic wb_xfer(input bit we, input logic [2:0] adr, input logic [7:0] d,
                          output logic [2:0] term, output logic [7:0] rd, output int lat);
      wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
      wb.wb_adr_i = adr;  wb.wb_dat_i = d;
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         lat++;
         if (wb.wb_ack_o || wb.wb_err_o || wb.wb_rty_o) break;
      end
      term = {wb.wb_ack_o, wb.wb_err_o, wb.wb_rty_o};
      rd   = wb.wb_dat_o;
      wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
   endtask

   task automatic do_wb(input bit we, input logic [2:0] adr, input logic [7:0] d, input string tag);
      logic [2:0] t_exp, t_got;
      logic [7:0] r_exp, r_got;
      int lat;
      model_wb(we, adr, d, t_exp, r_exp);
      wb_xfer(we, adr, d, t_got, r_got, lat);
      check({tag, " term"}, t_got, t_exp);
      check({tag, " latency"}, lat, 1);
      if (!we || adr > 3'd4) check({tag, " dat"}, r_got, r_exp);
      @(posedge clk); #1;
      check({tag, " drop"}, {wb.wb_ack_o, wb.wb_err_o, wb.wb_rty_o}, 3'b000);
      check({tag, " inta"}, wb.wb_inta_o, m_inta());
   endtask

   task automatic rx_drive(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      check("rx_ready", rx_ready, m_en && m_rx.size() < DEPTH);
      @(posedge clk); #1;
      if (m_en) begin
         if (m_rx.size() < DEPTH) m_rx.push_back(b);
         else m_ovr = 1;
      end
      rx_valid = 1'b0;
   endtask

   task automatic tx_take();
      bit exp_v;
      tx_ready = 1'b1;
      exp_v = m_en && m_tx.size() > 0;
      check("tx_valid", tx_valid, exp_v);
      if (exp_v) check("tx_data", tx_data, m_tx[0]);
      @(posedge clk); #1;
      if (exp_v) void'(m_tx.pop_front());
      tx_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0; wb.wb_adr_i = 0; wb.wb_dat_i = 0;
      m_reset();
      #1 rst = 1'b1;
      #1;
      check("reset outputs", {wb.wb_ack_o, wb.wb_err_o, wb.wb_rty_o, wb.wb_inta_o,
                              wb.wb_dat_o, tx_valid, rx_ready}, 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;

      // Reset state
      do_wb(0, ADR_STATUS, 0, "rst status");
      do_wb(0, ADR_CTRL,   0, "rst ctrl");

      // TX fill, overflow retry, ordered drain
      do_wb(1, ADR_CTRL, 8'h01, "en");
      for (int i = 0; i < 16; i++) do_wb(1, ADR_DATA, 8'(8'h11 + i), "tx fill");
      do_wb(0, ADR_TXCNT,  0, "txcnt full");
      do_wb(0, ADR_STATUS, 0, "status tx full");
      do_wb(1, ADR_DATA, 8'h99, "tx 17th");
      do_wb(0, ADR_TXCNT,  0, "txcnt after rty");
      for (int i = 0; i < 17; i++) tx_take();

      // RX push and reads
      rx_drive(8'hA5);
      rx_drive(8'h5A);
      do_wb(0, ADR_RXCNT, 0, "rxcnt 2");
      do_wb(0, ADR_DATA,  0, "rx rd1");
      do_wb(0, ADR_DATA,  0, "rx rd2");
      do_wb(0, ADR_DATA,  0, "rx rd empty");

      // RX overflow, interrupt, flush
      do_wb(1, ADR_CTRL, 8'h03, "en rxie");
      for (int i = 0; i < 16; i++) rx_drive(8'($urandom));
      rx_drive(8'hEE);
      do_wb(0, ADR_STATUS, 0, "status ovr");
      do_wb(0, ADR_RXCNT,  0, "rxcnt full");
      do_wb(1, ADR_CTRL, 8'h83, "flush");
      do_wb(0, ADR_TXCNT,  0, "txcnt flushed");
      do_wb(0, ADR_RXCNT,  0, "rxcnt flushed");
      do_wb(0, ADR_STATUS, 0, "status flushed");
      do_wb(0, ADR_CTRL,   0, "ctrl after flush");

      // Invalid addresses
      do_wb(0, 3'd6, 0,     "err rd");
      do_wb(1, 3'd5, 8'h81, "err wr");
      do_wb(1, 3'd7, 8'h42, "err wr7");
      do_wb(1, ADR_STATUS, 8'hFF, "ro wr");
      do_wb(0, ADR_STATUS, 0, "status after err");
      do_wb(0, ADR_CTRL,   0, "ctrl after err");

      // TX at count 8 with simultaneous WB push and stream pop
      do_wb(1, ADR_CTRL, 8'h01, "en only");
      for (int i = 0; i < 8; i++) do_wb(1, ADR_DATA, 8'($urandom), "tx8");
      do_wb(0, ADR_TXCNT, 0, "txcnt 8");
      wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = 1; wb.wb_adr_i = ADR_DATA; wb.wb_dat_i = 8'hC3;
      tx_ready = 1'b1;
      check("sim tx_valid", tx_valid, 1'b1);
      check("sim tx_data", tx_data, m_tx[0]);
      @(posedge clk); #1;
      tx_ready = 1'b0;
      check("sim term", {wb.wb_ack_o, wb.wb_err_o, wb.wb_rty_o}, T_ACK);
      void'(m_tx.pop_front());
      m_tx.push_back(8'hC3);
      wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0;
      @(posedge clk); #1;
      do_wb(0, ADR_TXCNT, 0, "txcnt sim");
      for (int i = 0; i < 9; i++) tx_take();
      do_wb(1, ADR_CTRL, 8'h05, "txie empty");

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [7:0] cv;
         case ($urandom_range(0, 9))
            0, 1: do_wb(1, ADR_DATA, 8'($urandom), "rnd wdata");
            2, 3: do_wb(0, ADR_DATA, 0, "rnd rdata");
            4:    do_wb(1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)),
                        8'($urandom) & 8'h7F, "rnd reg");
            5: begin
               cv = 8'($urandom_range(0, 7));
               cv[0] = ($urandom_range(0, 3) != 0);
               if ($urandom_range(0, 7) == 0) cv[7] = 1'b1;
               do_wb(1, ADR_CTRL, cv, "rnd ctrl");
            end
            6, 7: rx_drive(8'($urandom));
            default: tx_take();
         endcase
      end

      // Reset in the middle of an access
      do_wb(1, ADR_CTRL, 8'h01, "pre-rst ctrl");
      do_wb(1, ADR_CTRL, 8'h81, "pre-rst flush");
      do_wb(1, ADR_DATA, 8'h77, "pre-rst push");
      do_wb(0, ADR_STATUS, 0, "pre-rst status");
      check("pre-rst tx_valid", tx_valid, 1'b1);
      wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = 0; wb.wb_adr_i = ADR_STATUS;
      #3 rst = 1'b1;
      #1;
      check("async reset outputs", {wb.wb_ack_o, wb.wb_err_o, wb.wb_rty_o, wb.wb_inta_o,
                                    wb.wb_dat_o, tx_valid, rx_ready}, 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("no term in reset", {wb.wb_ack_o, wb.wb_err_o, wb.wb_rty_o}, 3'b000);
      end
      wb.wb_cyc_i = 0; wb.wb_stb_i = 0;
      m_reset();
      #2 rst = 1'b0;
      @(posedge clk); #1;
      do_wb(0, ADR_TXCNT,  0, "post-rst txcnt");
      do_wb(0, ADR_RXCNT,  0, "post-rst rxcnt");
      do_wb(0, ADR_STATUS, 0, "post-rst status");
      do_wb(0, ADR_CTRL,   0, "post-rst ctrl");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
